// File: rtl/opseq_pkg.sv
// Shared types and constants for the register operand sequencer.
package opseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  localparam logic [1:0] OP_IMM  = 2'b00;
  localparam logic [1:0] OP_CALC = 2'b01;
  localparam logic [1:0] OP_COPY = 2'b10;

  // Indices 6 and 7 are the external in/out ports, not bank registers.
  localparam logic [2:0] REG_IMM_DST  = 3'd0;
  localparam logic [2:0] REG_CALC_A   = 3'd1;
  localparam logic [2:0] REG_CALC_B   = 3'd2;
  localparam logic [2:0] REG_CALC_DST = 3'd3;
  localparam logic [2:0] PORT_IN      = 3'd6;
  localparam logic [2:0] PORT_OUT     = 3'd7;

endpackage

// File: rtl/opseq_decode.sv
// Combinational instruction decoder: opcode class, source/destination index,
// ALU function and legality for the configured bank size.
module opseq_decode
  import opseq_pkg::*;
#(
  parameter int NUM_REGS = 6
) (
  input  logic [7:0] instr,
  output logic [1:0] op,
  output logic [2:0] src,
  output logic [2:0] dst,
  output logic [2:0] fn,
  output logic       legal
);

  logic src_ok;
  logic dst_ok;

  // A source may be a bank register or the input port; a destination may be
  // a bank register or the output port.
  assign src_ok = (instr[5:3] < 3'(NUM_REGS)) || (instr[5:3] == PORT_IN);
  assign dst_ok = (instr[2:0] < 3'(NUM_REGS)) || (instr[2:0] == PORT_OUT);

  always_comb begin
    op    = instr[7:6];
    src   = instr[5:3];
    dst   = instr[2:0];
    fn    = instr[2:0];
    legal = 1'b0;
    case (instr[7:6])
      OP_IMM: begin
        dst   = REG_IMM_DST;
        legal = 1'b1;
      end
      OP_CALC: begin
        src   = REG_CALC_A;
        dst   = REG_CALC_DST;
        legal = 1'b1;
      end
      OP_COPY: legal = src_ok && dst_ok;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_operand_sequencer.sv
// Sequences IMM / COPY / CALC instructions onto the register bank and ALU.
// Optional retire counter port enabled by defining OPSEQ_RETIRE_CNT_EN.
module reg_operand_sequencer
  import opseq_pkg::*;
#(
  parameter int NUM_REGS = 6,
  parameter int ALU_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [NUM_REGS-1:0] load_sel,
  output logic [NUM_REGS-1:0] input_sel,
  output logic [NUM_REGS-1:0] save_sel,
  output logic [7:0]          save_value,
  input  logic [7:0]          bus1,
  input  logic [7:0]          bus2,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [2:0]          alu_fn,
  input  logic [7:0]          alu_result,
  input  logic [7:0]          ext_in,
  output logic [7:0]          ext_out,
  output logic                ext_out_valid,
  output logic                illegal
`ifdef OPSEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]         retire_cnt
`endif
);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] src_q, src_d;
  logic [2:0] dst_q, dst_d;
  logic [2:0] fn_q, fn_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  logic       illegal_q, illegal_d;
  logic [7:0] ext_out_q, ext_out_d;
  logic       ext_vld_q, ext_vld_d;

  logic [1:0] dec_op;
  logic [2:0] dec_src, dec_dst, dec_fn;
  logic       dec_legal;

  opseq_decode #(.NUM_REGS(NUM_REGS)) u_decode (
    .instr (instr),
    .op    (dec_op),
    .src   (dec_src),
    .dst   (dec_dst),
    .fn    (dec_fn),
    .legal (dec_legal)
  );

  function automatic logic [NUM_REGS-1:0] onehot(input logic [2:0] idx);
    onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    dst_d      = dst_q;
    fn_d       = fn_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    ext_out_d  = ext_out_q;
    illegal_d  = 1'b0;
    ext_vld_d  = 1'b0;
    load_sel   = '0;
    input_sel  = '0;
    save_sel   = '0;
    save_value = 8'h00;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_fn     = 3'b000;
    case (state_q)
      IDLE: begin
        if (instr_valid && ready_q) begin
          if (!dec_legal) begin
            illegal_d = 1'b1;
          end else begin
            op_d  = dec_op;
            src_d = dec_src;
            dst_d = dec_dst;
            fn_d  = dec_fn;
            if (dec_op == OP_IMM) begin
              op_a_d  = {2'b00, instr[5:0]};
              state_d = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (op_q == OP_CALC) begin
          load_sel  = onehot(REG_CALC_A);
          input_sel = onehot(REG_CALC_B);
          op_a_d    = bus1;
          op_b_d    = bus2;
          cnt_d     = 3'(ALU_LAT - 1);
          state_d   = EXEC;
        end else begin
          if (src_q == PORT_IN) begin
            op_a_d = ext_in;
          end else begin
            load_sel = onehot(src_q);
            op_a_d   = bus1;
          end
          state_d = WRITE;
        end
      end
      EXEC: begin
        alu_a  = op_a_q;
        alu_b  = op_b_q;
        alu_fn = fn_q;
        if (cnt_q == 3'd0) begin
          op_a_d  = alu_result;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      WRITE: begin
        save_value = op_a_q;
        if (op_q == OP_COPY && dst_q == PORT_OUT) begin
          ext_out_d = op_a_q;
          ext_vld_d = 1'b1;
        end else begin
          save_sel = onehot(dst_q);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so that ready is low on the first cycle after reset.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      src_q     <= 3'd0;
      dst_q     <= 3'd0;
      fn_q      <= 3'd0;
      op_a_q    <= 8'h00;
      op_b_q    <= 8'h00;
      cnt_q     <= 3'd0;
      ready_q   <= 1'b0;
      illegal_q <= 1'b0;
      ext_out_q <= 8'h00;
      ext_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      fn_q      <= fn_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      illegal_q <= illegal_d;
      ext_out_q <= ext_out_d;
      ext_vld_q <= ext_vld_d;
    end
  end

  assign instr_ready   = ready_q;
  assign illegal       = illegal_q;
  assign ext_out       = ext_out_q;
  assign ext_out_valid = ext_vld_q;

`ifdef OPSEQ_RETIRE_CNT_EN
  logic [15:0] retire_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= 16'h0000;
    end else if (state_q == WRITE) begin
      retire_q <= retire_q + 16'h0001;
    end
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_reg_operand_sequencer.sv
// Directed self-checking bench for reg_operand_sequencer (NUM_REGS=6, ALU_LAT=2).
module tb_reg_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [5:0] load_sel, input_sel, save_sel;
  logic [7:0] save_value, bus1, bus2, alu_a, alu_b, alu_result, ext_in, ext_out;
  logic [2:0] alu_fn;
  logic       ext_out_valid, illegal;
`ifdef OPSEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_operand_sequencer #(.NUM_REGS(6), .ALU_LAT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .load_sel      (load_sel),
    .input_sel     (input_sel),
    .save_sel      (save_sel),
    .save_value    (save_value),
    .bus1          (bus1),
    .bus2          (bus2),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_fn        (alu_fn),
    .alu_result    (alu_result),
    .ext_in        (ext_in),
    .ext_out       (ext_out),
    .ext_out_valid (ext_out_valid),
    .illegal       (illegal)
`ifdef OPSEQ_RETIRE_CNT_EN
    ,
    .retire_cnt    (retire_cnt)
`endif
  );

  task automatic test_reset();
    rst = 1'b1; instr = 8'h00; instr_valid = 1'b0;
    bus1 = 8'h00; bus2 = 8'h00; alu_result = 8'h00; ext_in = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({instr_ready, load_sel, input_sel, save_sel, save_value, alu_a, alu_b, alu_fn,
         ext_out, ext_out_valid, illegal} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b load=%b input=%b save=%b sv=%h a=%h b=%h fn=%b eo=%h eov=%b ill=%b, want all 0",
               instr_ready, load_sel, input_sel, save_sel, save_value, alu_a, alu_b, alu_fn,
               ext_out, ext_out_valid, illegal);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready_after: got %b want 1", instr_ready);
    end
    $display("reset: outputs cleared, ready after release");
  endtask

  task automatic test_imm();
    instr = 8'h2A; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if (save_sel !== 6'b000001 || save_value !== 8'h2A || instr_ready !== 1'b0) begin
      bad++;
      $display("FAIL imm_write: got save_sel=%b save_value=%h ready=%b want 000001 2a 0",
               save_sel, save_value, instr_ready);
    end
    @(negedge clk);
    total++;
    if (save_sel !== 6'b000000 || instr_ready !== 1'b1) begin
      bad++; $display("FAIL imm_idle: got save_sel=%b ready=%b want 000000 1", save_sel, instr_ready);
    end
    $display("imm 2a: save reg0");
  endtask

  task automatic test_calc();
    instr = 8'h44; instr_valid = 1'b1; bus1 = 8'h05; bus2 = 8'h03; alu_result = 8'h77;
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if (load_sel !== 6'b000010 || input_sel !== 6'b000100 || save_sel !== 6'b000000) begin
      bad++;
      $display("FAIL calc_read: got load=%b input=%b save=%b want 000010 000100 000000",
               load_sel, input_sel, save_sel);
    end
    @(negedge clk);
    bus1 = 8'hFF; bus2 = 8'hFF;
    total++;
    if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_fn !== 3'b100 || load_sel !== 6'b0) begin
      bad++;
      $display("FAIL calc_exec1: got a=%h b=%h fn=%b load=%b want 05 03 100 000000",
               alu_a, alu_b, alu_fn, load_sel);
    end
    alu_result = 8'h08;
    @(negedge clk);
    total++;
    if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_fn !== 3'b100 || save_sel !== 6'b0) begin
      bad++;
      $display("FAIL calc_exec2: got a=%h b=%h fn=%b save=%b want 05 03 100 000000",
               alu_a, alu_b, alu_fn, save_sel);
    end
    @(negedge clk);
    alu_result = 8'h00;
    total++;
    if (save_sel !== 6'b001000 || save_value !== 8'h08) begin
      bad++;
      $display("FAIL calc_write: got save_sel=%b save_value=%h want 001000 08", save_sel, save_value);
    end
    @(negedge clk);
    $display("calc fn=100 05,03 -> 08 into reg3");
  endtask

  task automatic test_copy_port();
    instr = 8'hB7; instr_valid = 1'b1; ext_in = 8'hC3;
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if (load_sel !== 6'b0 || input_sel !== 6'b0 || save_sel !== 6'b0) begin
      bad++; $display("FAIL copy_port_read: got load=%b input=%b save=%b want 0", load_sel, input_sel, save_sel);
    end
    @(negedge clk);
    ext_in = 8'h00;
    total++;
    if (save_sel !== 6'b0 || ext_out_valid !== 1'b0) begin
      bad++; $display("FAIL copy_port_write: got save=%b eov=%b want 000000 0", save_sel, ext_out_valid);
    end
    @(negedge clk);
    total++;
    if (ext_out !== 8'hC3 || ext_out_valid !== 1'b1) begin
      bad++; $display("FAIL copy_port_out: got ext_out=%h eov=%b want c3 1", ext_out, ext_out_valid);
    end
    @(negedge clk);
    total++;
    if (ext_out !== 8'hC3 || ext_out_valid !== 1'b0) begin
      bad++; $display("FAIL copy_port_pulse: got ext_out=%h eov=%b want c3 0", ext_out, ext_out_valid);
    end
    $display("copy in->out c3");
  endtask

  task automatic test_copy_reg(input logic [7:0] ins, input logic [7:0] val,
                               input logic [5:0] exp_load, input logic [5:0] exp_save);
    instr = ins; instr_valid = 1'b1; bus1 = val;
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if (load_sel !== exp_load || input_sel !== 6'b0) begin
      bad++; $display("FAIL copy_reg_read %h: got load=%b input=%b want %b 000000", ins, load_sel, input_sel, exp_load);
    end
    @(negedge clk);
    bus1 = 8'h00;
    total++;
    if (save_sel !== exp_save || save_value !== val || load_sel !== 6'b0) begin
      bad++; $display("FAIL copy_reg_write %h: got save=%b sv=%h want %b %h", ins, save_sel, save_value, exp_save, val);
    end
    @(negedge clk);
    $display("copy %h value %h", ins, val);
  endtask

  task automatic test_illegal(input logic [7:0] ins);
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if (illegal !== 1'b1 || instr_ready !== 1'b1 || load_sel !== 6'b0 || save_sel !== 6'b0) begin
      bad++; $display("FAIL illegal_pulse %h: got ill=%b ready=%b load=%b save=%b want 1 1 0 0",
                      ins, illegal, instr_ready, load_sel, save_sel);
    end
    @(negedge clk);
    total++;
    if (illegal !== 1'b0 || save_sel !== 6'b0 || load_sel !== 6'b0 || instr_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_after %h: got ill=%b save=%b load=%b ready=%b want 0 0 0 1",
                      ins, illegal, save_sel, load_sel, instr_ready);
    end
    $display("illegal %h rejected", ins);
  endtask

  task automatic test_back_to_back();
    instr = 8'h01; instr_valid = 1'b1;
    @(negedge clk);
    instr = 8'h15;
    total++;
    if (save_value !== 8'h01 || instr_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_first: got sv=%h ready=%b want 01 0", save_value, instr_ready);
    end
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1 || save_sel !== 6'b0) begin
      bad++; $display("FAIL b2b_idle: got ready=%b save=%b want 1 000000", instr_ready, save_sel);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if (save_sel !== 6'b000001 || save_value !== 8'h15) begin
      bad++; $display("FAIL b2b_second: got save=%b sv=%h want 000001 15", save_sel, save_value);
    end
    @(negedge clk);
    $display("back-to-back imm 01 then 15");
  endtask

  task automatic test_reset_mid_exec();
    instr = 8'h41; instr_valid = 1'b1; bus1 = 8'h09; bus2 = 8'h0A; alu_result = 8'h55;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    total++;
    if (alu_a !== 8'h09) begin
      bad++; $display("FAIL rst_exec_pre: got alu_a=%h want 09", alu_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({instr_ready, load_sel, input_sel, save_sel, save_value, alu_a, alu_b, alu_fn,
         ext_out_valid, illegal} !== '0) begin
      bad++;
      $display("FAIL rst_exec_outputs: got ready=%b load=%b save=%b sv=%h a=%h b=%h fn=%b want all 0",
               instr_ready, load_sel, save_sel, save_value, alu_a, alu_b, alu_fn);
    end
    @(negedge clk);
    total++;
    if (save_sel !== 6'b0 || instr_ready !== 1'b1) begin
      bad++; $display("FAIL rst_exec_nosave: got save=%b ready=%b want 000000 1", save_sel, instr_ready);
    end
    alu_result = 8'h00;
    instr = 8'h11; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if (save_sel !== 6'b000001 || save_value !== 8'h11) begin
      bad++; $display("FAIL rst_exec_recover: got save=%b sv=%h want 000001 11", save_sel, save_value);
    end
    @(negedge clk);
    $display("reset during exec aborted, imm 11 afterwards");
  endtask

`ifdef OPSEQ_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    // One IMM retired since the mid-exec reset; add two more legal and one illegal.
    test_illegal(8'hC0);
    test_copy_reg(8'h9B, 8'h3C, 6'b001000, 6'b001000);
    instr = 8'h07; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    total++;
    if (retire_cnt !== 16'd3) begin
      bad++; $display("FAIL retire_cnt: got %0d want 3", retire_cnt);
    end
    $display("retire_cnt checked");
  endtask
`endif

  initial begin
    test_reset();
    test_imm();
    test_calc();
    test_copy_port();
    test_copy_reg(8'h94, 8'h5A, 6'b000100, 6'b010000);
    test_copy_reg(8'h9B, 8'hA5, 6'b001000, 6'b001000);
    test_illegal(8'hC0);
    test_illegal(8'hB8);
    test_illegal(8'h86);
    test_back_to_back();
    test_reset_mid_exec();
`ifdef OPSEQ_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_operand_sequencer.md
Name: reg_operand_sequencer

Overview:
- Control stage directly upstream of the 8-bit register bank.
- Accepts one 8-bit instruction per handshake and drives per-register read-enables for bus 1 and bus 2, plus save strobes and save data.
- Captures bus operands, hands them to an external ALU and writes the result back, one instruction at a time.
- Sits between instruction fetch and the register bank/ALU.

Parameters:
- NUM_REGS, 6, registers in the bank; register indices 0..NUM_REGS-1; legal range 4..6.
- ALU_LAT, 1, cycles from ALU operand presentation to a valid alu_result; legal range 1..7.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- instr  input  8  instruction byte.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  sequencer accepts instr this cycle.
- load_sel  output  NUM_REGS  one-hot; drives each register's Load (bus 1 enable).
- input_sel  output  NUM_REGS  one-hot; drives each register's Input (bus 2 enable).
- save_sel  output  NUM_REGS  one-hot; drives each register's Save.
- save_value  output  8  shared Save_value for all registers.
- bus1  input  8  register read bus 1.
- bus2  input  8  register read bus 2.
- alu_a  output  8  ALU operand A.
- alu_b  output  8  ALU operand B.
- alu_fn  output  3  ALU function code.
- alu_result  input  8  ALU result.
- ext_in  input  8  external input port (pseudo-register 6).
- ext_out  output  8  external output port (pseudo-register 7).
- ext_out_valid  output  1  one-cycle pulse when ext_out is updated.
- illegal  output  1  one-cycle pulse when an instruction is rejected.

Behaviour:
- Reset values: all outputs 0, state IDLE.
- A reset asserted mid-operation aborts the instruction with no save pulse; outputs are 0 on the cycle after the reset edge.
- instr_ready is 1 only in IDLE. An instruction is accepted on a rising edge where instr_valid and instr_ready are both 1.
- Instruction decode, by instr[7:6]:
  - 00 IMM: reg0 <= {2'b00, instr[5:0]}.
  - 01 CALC: alu_fn = instr[2:0]; reg3 <= reg1 op reg2. instr[5:3] is ignored.
  - 10 COPY: src = instr[5:3], dst = instr[2:0].
  - 11: illegal.
- Illegal cases:
  - opcode 11;
  - COPY with src == 7, dst == 6, or either index in NUM_REGS..5.
  - On any illegal case: pulse illegal for 1 cycle, perform no strobes, remain in IDLE.
- States: IDLE, READ, EXEC, WRITE.
  - IMM: IDLE -> WRITE.
  - COPY: IDLE -> READ -> WRITE.
  - CALC: IDLE -> READ -> EXEC -> WRITE.
  - WRITE always returns to IDLE.
- READ state (exactly 1 cycle):
  - COPY with src < NUM_REGS: load_sel[src] = 1; bus1 is captured into op_a at the end of the cycle.
  - COPY with src == 6: no select is asserted; ext_in is captured into op_a.
  - CALC: load_sel[1] = 1 and input_sel[2] = 1; bus1 is captured into op_a and bus2 into op_b.
- EXEC state:
  - alu_a = op_a and alu_b = op_b, held stable for ALU_LAT cycles; alu_fn is held.
  - alu_result is captured into op_a on the last EXEC cycle. A down-counter sized for 3 bits is used.
- WRITE state (exactly 1 cycle):
  - save_value = op_a (for IMM, the immediate value).
  - save_sel[dst] = 1, where dst is 0 for IMM and 3 for CALC.
  - COPY with dst == 7: no save_sel is asserted; ext_out <= op_a and ext_out_valid pulses on the following cycle.
- Outside READ and WRITE, all selects are 0. At most one bit of each select vector is set in any cycle.
- COPY with src == dst is legal: the register is rewritten with its own value.
- Latency from acceptance edge to save_sel high: IMM 1 cycle, COPY 2 cycles, CALC 2+ALU_LAT cycles.
- Throughput: one instruction in flight; the next instruction is accepted in the IDLE cycle after WRITE.

Optional Feature:
- Macro: OPSEQ_RETIRE_CNT_EN.
- Defined: adds output port retire_cnt [15:0]. It is cleared by reset, increments on each WRITE cycle, wraps 0xFFFF -> 0, and is not incremented by illegal instructions.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package opseq_pkg:
  - state enum (IDLE, READ, EXEC, WRITE);
  - opcode localparams OP_IMM = 2'b00, OP_CALC = 2'b01, OP_COPY = 2'b10;
  - localparams REG_IMM_DST = 0, REG_CALC_A = 1, REG_CALC_B = 2, REG_CALC_DST = 3, PORT_IN = 6, PORT_OUT = 7.
- One sub-module, opseq_decode: purely combinational; maps instr to {class, src, dst, fn, legal}.

Test Plan:
- IMM 8'h2A accepted -> next cycle save_sel = 6'b000001 and save_value = 8'h2A; instr_ready low for that cycle.
- CALC, fn = 3'b100, with reg1 = 8'h05 and reg2 = 8'h03 on bus1/bus2, ALU_LAT = 2, alu_result = 8'h08 -> READ cycle shows load_sel = 000010 and input_sel = 000100; save_sel = 001000 with save_value = 8'h08 exactly 4 cycles after acceptance.
- COPY src = 6, dst = 7, ext_in = 8'hC3 -> no selects asserted; ext_out = 8'hC3 and ext_out_valid pulses once, 3 cycles after acceptance.
- instr = 8'hC0 (opcode 11), and separately COPY src = 7 -> illegal pulses 1 cycle each; all selects stay 0; instr_ready remains 1.
- rst asserted during EXEC of a CALC -> no save pulse; all outputs 0 the cycle after; the next IMM instruction executes normally.
- With OPSEQ_RETIRE_CNT_EN: 3 legal instructions plus 1 illegal -> retire_cnt = 3.
